// File: rtl/alu_arbiter_pkg.sv
// Shared definitions for the two-requester ALU arbiter: FSM encoding,
// default datapath widths (common with the alu) and a one-hot helper.
package alu_arbiter_pkg;

  localparam int ALU_WIDTH = 32;
  localparam int ALU_SEL_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } arb_state_e;

  function automatic logic [1:0] onehot2(input logic idx);
    return idx ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin grant: a lone request wins outright, a tie goes to
// the requester that was not granted last.
module rr_arb2
  import alu_arbiter_pkg::*;
(
  input  logic [1:0] i_req,
  input  logic       i_last_grant,
  output logic [1:0] o_grant
);

  // one-hot grant decode
  always_comb begin
    o_grant = 2'b00;
    case (i_req)
      2'b01:   o_grant = 2'b01;
      2'b10:   o_grant = 2'b10;
      2'b11:   o_grant = onehot2(~i_last_grant);
      default: o_grant = 2'b00;
    endcase
  end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one clocked ALU between two valid/ready requesters, returning the
// result to the granted requester as a single-cycle response pulse.
module alu_arbiter
  import alu_arbiter_pkg::*;
#(
  parameter int WIDTH   = ALU_WIDTH,
  parameter int SEL_W   = ALU_SEL_W,
  parameter int ALU_LAT = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic [SEL_W-1:0] req0_sel,
  output logic             rsp0_valid,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic [SEL_W-1:0] req1_sel,
  output logic             rsp1_valid,
  output logic [WIDTH-1:0] rsp_result,
  output logic             rsp_carry,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [SEL_W-1:0] alu_sel,
  input  logic [WIDTH-1:0] alu_out,
  input  logic             alu_carry
);

  localparam int CNT_W = (ALU_LAT > 1) ? $clog2(ALU_LAT) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(ALU_LAT - 1);

  arb_state_e       r_state;
  logic             r_last_grant;
  logic             r_grant_id;
  logic [CNT_W-1:0] r_cnt;
  logic             r_rsp0_valid;
  logic             r_rsp1_valid;
  logic [WIDTH-1:0] r_rsp_result;
  logic             r_rsp_carry;
  logic [WIDTH-1:0] r_alu_a;
  logic [WIDTH-1:0] r_alu_b;
  logic [SEL_W-1:0] r_alu_sel;

  logic [1:0] w_req;
  logic [1:0] w_grant;
  logic [1:0] w_ready;

  assign w_req = {req1_valid, req0_valid};

  rr_arb2 u_rr_arb2 (
    .i_req        (w_req),
    .i_last_grant (r_last_grant),
    .o_grant      (w_grant)
  );

  // Handshake is combinational on this cycle's valids; suppressed while reset is held.
  assign w_ready    = ((r_state == ST_IDLE) && !rst) ? w_grant : 2'b00;
  assign req0_ready = w_ready[0];
  assign req1_ready = w_ready[1];

  assign rsp0_valid = r_rsp0_valid;
  assign rsp1_valid = r_rsp1_valid;
  assign rsp_result = r_rsp_result;
  assign rsp_carry  = r_rsp_carry;
  assign alu_a      = r_alu_a;
  assign alu_b      = r_alu_b;
  assign alu_sel    = r_alu_sel;

  // arbitration FSM, latency counter and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_last_grant <= 1'b1;
      r_grant_id   <= 1'b0;
      r_cnt        <= {CNT_W{1'b0}};
      r_rsp0_valid <= 1'b0;
      r_rsp1_valid <= 1'b0;
      r_rsp_result <= {WIDTH{1'b0}};
      r_rsp_carry  <= 1'b0;
      r_alu_a      <= {WIDTH{1'b0}};
      r_alu_b      <= {WIDTH{1'b0}};
      r_alu_sel    <= {SEL_W{1'b0}};
    end else begin
      r_rsp0_valid <= 1'b0;
      r_rsp1_valid <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_ready != 2'b00) begin
            r_grant_id   <= w_ready[1];
            r_last_grant <= w_ready[1];
            r_alu_a      <= w_ready[1] ? req1_a   : req0_a;
            r_alu_b      <= w_ready[1] ? req1_b   : req0_b;
            r_alu_sel    <= w_ready[1] ? req1_sel : req0_sel;
            r_state      <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          r_cnt   <= CNT_LOAD;
          r_state <= ST_WAIT;
        end
        ST_WAIT: begin
          if (r_cnt == {CNT_W{1'b0}}) begin
            r_rsp_result <= alu_out;
            r_rsp_carry  <= alu_carry;
            r_rsp0_valid <= ~r_grant_id;
            r_rsp1_valid <= r_grant_id;
            r_state      <= ST_RESP;
          end else begin
            r_cnt <= r_cnt - CNT_W'(1);
          end
        end
        ST_RESP: r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench: two arbiter instances (ALU_LAT=1 and 3), each with a
// behavioural ALU and a cycle-level scoreboard of the arbitration rules.
module tb_alu_arbiter;

  typedef struct {
    bit          who;
    logic [31:0] res;
    logic        c;
    int          due;
  } pend_t;

  typedef struct {
    bit          req;
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  sel;
    logic [31:0] exp_res;
    logic        exp_c;
  } vec_t;

  logic clk = 1'b0;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;

  logic        s_rst   [2];
  logic [1:0]  s_valid [2];
  logic [31:0] s_a     [2][2];
  logic [31:0] s_b     [2][2];
  logic [3:0]  s_sel   [2][2];

  logic [1:0]  w_rdy [2];
  logic [1:0]  w_rsp [2];
  logic [31:0] w_res [2];
  logic        w_c   [2];
  logic [31:0] w_aa  [2];
  logic [31:0] w_ab  [2];
  logic [3:0]  w_as  [2];
  int          pend_cnt [2];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural ALU: result per opcode, carry is always the carry of A+B.
  function automatic logic [32:0] alu_f(input logic [31:0] a, input logic [31:0] b, input logic [3:0] s);
    logic [32:0] sum;
    logic [31:0] r;
    sum = {1'b0, a} + {1'b0, b};
    case (s)
      4'h0: r = sum[31:0];
      4'h1: r = a - b;
      4'h2: r = a * b;
      4'h3: r = (b == 32'd0) ? 32'd0 : a / b;
      4'h4: r = a << 1;
      4'h5: r = a >> 1;
      4'h6: r = {a[30:0], a[31]};
      4'h7: r = {a[0], a[31:1]};
      4'h8: r = a & b;
      4'h9: r = a | b;
      4'hA: r = a ^ b;
      4'hB: r = ~(a | b);
      4'hC: r = ~(a & b);
      4'hD: r = ~(a ^ b);
      4'hE: r = (a > b) ? 32'd1 : 32'd0;
      default: r = (a == b) ? 32'd1 : 32'd0;
    endcase
    return {sum[32], r};
  endfunction

  task automatic chk(input string nm, input int d, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s dut%0d @cyc %0d: got %0h want %0h", nm, d, cyc, act, exp);
    end
  endtask

  for (genvar g = 0; g < 2; g++) begin : g_dut
    localparam int LAT = (g == 0) ? 1 : 3;
    logic        rdy0, rdy1, rsp0, rsp1, c, alu_c;
    logic [31:0] res, aa, ab, alu_o;
    logic [3:0]  as;
    logic [32:0] pipe_r [LAT];
    pend_t       q [$];
    int          free_cyc = 0;
    bit          armed = 1'b0;
    bit          last = 1'b1;

    alu_arbiter #(.WIDTH(32), .SEL_W(4), .ALU_LAT(LAT)) u_dut (
      .clk(clk), .rst(s_rst[g]),
      .req0_valid(s_valid[g][0]), .req0_ready(rdy0),
      .req0_a(s_a[g][0]), .req0_b(s_b[g][0]), .req0_sel(s_sel[g][0]), .rsp0_valid(rsp0),
      .req1_valid(s_valid[g][1]), .req1_ready(rdy1),
      .req1_a(s_a[g][1]), .req1_b(s_b[g][1]), .req1_sel(s_sel[g][1]), .rsp1_valid(rsp1),
      .rsp_result(res), .rsp_carry(c),
      .alu_a(aa), .alu_b(ab), .alu_sel(as),
      .alu_out(alu_o), .alu_carry(alu_c)
    );

    always @(posedge clk) begin
      pipe_r[0] <= alu_f(aa, ab, as);
      for (int i = 1; i < LAT; i++) pipe_r[i] <= pipe_r[i-1];
    end
    assign alu_o = pipe_r[LAT-1][31:0];
    assign alu_c = pipe_r[LAT-1][32];

    assign w_rdy[g] = {rdy1, rdy0};
    assign w_rsp[g] = {rsp1, rsp0};
    assign w_res[g] = res;
    assign w_c[g]   = c;
    assign w_aa[g]  = aa;
    assign w_ab[g]  = ab;
    assign w_as[g]  = as;

    // Scoreboard: predicts ready and response pulses cycle by cycle.
    always @(negedge clk) begin
      logic [1:0]  exp_rdy, exp_rsp;
      logic [32:0] r;
      bit          w;
      pend_t       p;
      exp_rdy = 2'b00;
      exp_rsp = 2'b00;
      w = 1'b0;
      if (q.size() > 0 && q[0].due == cyc) exp_rsp = q[0].who ? 2'b10 : 2'b01;
      if (!s_rst[g] && cyc >= free_cyc && s_valid[g] != 2'b00) begin
        w = (s_valid[g] == 2'b11) ? ~last : s_valid[g][1];
        exp_rdy = w ? 2'b10 : 2'b01;
      end
      if (armed) begin
        chk("ready", g, w_rdy[g], exp_rdy);
        chk("rsp_valid", g, w_rsp[g], exp_rsp);
        if (exp_rsp != 2'b00) begin
          chk("rsp_result", g, res, q[0].res);
          chk("rsp_carry", g, c, q[0].c);
        end
      end
      if (exp_rsp != 2'b00) void'(q.pop_front());
      if (exp_rdy != 2'b00) begin
        r = alu_f(s_a[g][w], s_b[g][w], s_sel[g][w]);
        p.who = w; p.res = r[31:0]; p.c = r[32]; p.due = cyc + LAT + 2;
        q.push_back(p);
        free_cyc = cyc + LAT + 3;
        last = w;
      end
      if (s_rst[g]) begin
        q.delete();
        free_cyc = cyc + 1;
        last = 1'b1;
        armed = 1'b1;
      end
      pend_cnt[g] = q.size();
    end
  end

  task automatic run_op(input int d, input int r, input logic [31:0] a, input logic [31:0] b,
                        input logic [3:0] sel, output logic [31:0] res, output logic c, output int lat);
    bit got;
    int t0;
    got = 1'b0; t0 = 0; lat = -1; res = 32'd0; c = 1'b0;
    @(posedge clk); #1;
    s_a[d][r] = a; s_b[d][r] = b; s_sel[d][r] = sel; s_valid[d][r] = 1'b1;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if (w_rdy[d][r]) begin got = 1'b1; t0 = cyc; end
    end
    chk("handshake_timeout", d, got, 1'b1);
    @(posedge clk); #1;
    s_valid[d][r] = 1'b0;
    s_a[d][r] = $urandom; s_b[d][r] = $urandom; s_sel[d][r] = 4'($urandom);
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if (w_rsp[d][r]) begin got = 1'b1; lat = cyc - t0; res = w_res[d]; c = w_c[d]; end
    end
    chk("response_timeout", d, got, 1'b1);
  endtask

  vec_t        vecs [9];
  logic [31:0] got_res;
  logic        got_c;
  int          lat, n, lastc;
  bit          hs;

  initial begin
    vecs[0] = '{1'b0, 32'h0000AE21, 32'h000025F0, 4'h0, 32'h0000D411, 1'b0};
    vecs[1] = '{1'b1, 32'hFFFFFFFF, 32'h00000001, 4'h0, 32'h00000000, 1'b1};
    vecs[2] = '{1'b0, 32'h00000010, 32'h00000003, 4'h1, 32'h0000000D, 1'b0};
    vecs[3] = '{1'b1, 32'h0000F0F0, 32'h0000FF00, 4'h8, 32'h0000F000, 1'b0};
    vecs[4] = '{1'b0, 32'h80000000, 32'h80000000, 4'h0, 32'h00000000, 1'b1};
    vecs[5] = '{1'b1, 32'h12345678, 32'h0F0F0F0F, 4'hA, 32'h1D3B5977, 1'b0};
    vecs[6] = '{1'b0, 32'h00000003, 32'h00000005, 4'h2, 32'h0000000F, 1'b0};
    vecs[7] = '{1'b1, 32'h00000007, 32'h00000007, 4'hF, 32'h00000001, 1'b0};
    vecs[8] = '{1'b0, 32'h00000005, 32'h00000007, 4'h1, 32'hFFFFFFFE, 1'b0};

    for (int d = 0; d < 2; d++) begin
      s_rst[d] = 1'b1; s_valid[d] = 2'b11;
      for (int r = 0; r < 2; r++) begin
        s_a[d][r] = 32'd100 + 32'(r); s_b[d][r] = 32'd7; s_sel[d][r] = 4'h0;
      end
    end

    // Reset held three edges with both requesters valid.
    repeat (2) @(posedge clk);
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      chk("reset_ready", d, w_rdy[d], 2'b00);
      chk("reset_rsp", d, w_rsp[d], 2'b00);
      chk("reset_result", d, w_res[d], 32'd0);
      chk("reset_carry", d, w_c[d], 1'b0);
      chk("reset_alu_a", d, w_aa[d], 32'd0);
      chk("reset_alu_b", d, w_ab[d], 32'd0);
      chk("reset_alu_sel", d, w_as[d], 4'd0);
    end
    @(posedge clk); #1;
    s_rst[0] = 1'b0; s_rst[1] = 1'b0;
    @(negedge clk);
    chk("first_grant", 0, w_rdy[0], 2'b01);
    chk("first_grant", 1, w_rdy[1], 2'b01);
    @(posedge clk); #1;
    s_valid[0] = 2'b00; s_valid[1] = 2'b00;
    repeat (8) @(posedge clk);

    // Table of single ops on the ALU_LAT=1 instance.
    for (int i = 0; i < 9; i++) begin
      run_op(0, int'(vecs[i].req), vecs[i].a, vecs[i].b, vecs[i].sel, got_res, got_c, lat);
      chk("vec_latency", 0, lat, 3);
      chk("vec_result", 0, got_res, vecs[i].exp_res);
      chk("vec_carry", 0, got_c, vecs[i].exp_c);
    end

    // Contention: both valid continuously, grants must alternate starting at 0.
    @(posedge clk); #1; s_rst[0] = 1'b1;
    @(posedge clk); #1; s_rst[0] = 1'b0; s_valid[0] = 2'b11;
    n = 0; lastc = 0;
    for (int i = 0; i < 60 && n < 6; i++) begin
      @(negedge clk);
      if (w_rdy[0] != 2'b00) begin
        chk("rr_order", 0, w_rdy[0], (n % 2 == 1) ? 2'b10 : 2'b01);
        if (n > 0) chk("rr_spacing", 0, cyc - lastc, 4);
        lastc = cyc;
        n++;
      end
      @(posedge clk); #1;
      for (int r = 0; r < 2; r++) begin
        s_a[0][r] = $urandom; s_b[0][r] = $urandom; s_sel[0][r] = 4'($urandom);
      end
    end
    chk("rr_count", 0, n, 6);
    s_valid[0] = 2'b00;
    repeat (8) @(posedge clk);

    // Latency sweep on ALU_LAT=3 with the other requester pressing.
    #1;
    s_a[1][1] = 32'd9; s_b[1][1] = 32'd4; s_sel[1][1] = 4'h1; s_valid[1][1] = 1'b1;
    run_op(1, 0, 32'h0000AE21, 32'h000025F0, 4'h0, got_res, got_c, lat);
    chk("lat3_latency", 1, lat, 5);
    chk("lat3_result", 1, got_res, 32'h0000D411);
    #1; s_valid[1][1] = 1'b0;
    repeat (10) @(posedge clk);

    // Reset while the op is in WAIT.
    #1;
    s_a[0][1] = 32'd50; s_b[0][1] = 32'd60; s_sel[0][1] = 4'h0; s_valid[0][1] = 1'b1;
    hs = 1'b0;
    for (int i = 0; i < 10 && !hs; i++) begin
      @(negedge clk);
      if (w_rdy[0][1]) hs = 1'b1;
    end
    chk("midrst_handshake", 0, hs, 1'b1);
    @(posedge clk); #1; s_valid[0][1] = 1'b0;
    @(posedge clk); #1; s_rst[0] = 1'b1;
    @(negedge clk);
    chk("midrst_no_rsp", 0, w_rsp[0], 2'b00);
    @(posedge clk); #1;
    s_rst[0] = 1'b0; s_valid[0][0] = 1'b1;
    s_a[0][0] = 32'd1; s_b[0][0] = 32'd2; s_sel[0][0] = 4'h0;
    @(negedge clk);
    chk("midrst_idle", 0, w_rdy[0], 2'b01);
    chk("midrst_no_rsp2", 0, w_rsp[0], 2'b00);
    @(posedge clk); #1; s_valid[0][0] = 1'b0;
    repeat (6) @(posedge clk);
    run_op(0, 1, 32'h00000011, 32'h00000022, 4'h0, got_res, got_c, lat);
    chk("midrst_next_result", 0, got_res, 32'h00000033);
    chk("midrst_next_latency", 0, lat, 3);

    // Random traffic on both instances, scoreboard does the checking.
    for (int i = 0; i < 600; i++) begin
      @(posedge clk); #1;
      for (int d = 0; d < 2; d++) begin
        s_rst[d] = ($urandom_range(0, 99) == 0);
        s_valid[d] = 2'($urandom);
        for (int r = 0; r < 2; r++) begin
          s_a[d][r] = $urandom; s_b[d][r] = $urandom_range(0, 15) == 0 ? 32'd0 : $urandom;
          s_sel[d][r] = 4'($urandom);
        end
      end
    end
    @(posedge clk); #1;
    for (int d = 0; d < 2; d++) begin s_rst[d] = 1'b0; s_valid[d] = 2'b00; end
    repeat (12) @(posedge clk);
    @(negedge clk);
    chk("drain_pending", 0, pend_cnt[0], 0);
    chk("drain_pending", 1, pend_cnt[1], 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
- Shares one clocked 32-bit ALU between two requesters (req0, req1).
- Each requester presents operands A, B and a 4-bit opcode using a valid/ready handshake.
- The arbiter grants requesters round-robin, drives the ALU inputs, waits ALU_LAT cycles and returns result plus carry to the granted requester as a one-cycle response pulse.
- Sits between the issue logic and the alu instance; the ALU itself is unchanged.

Parameters:
- WIDTH, 32, operand/result width.
- SEL_W, 4, opcode width.
- ALU_LAT, 1, clock cycles from ALU input capture to valid ALU_Out/CarryOut (must be >=1).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- req0_valid  in  1  requester 0 has an op.
- req0_ready  out  1  requester 0 op accepted this cycle.
- req0_a, req0_b  in  WIDTH  requester 0 operands.
- req0_sel  in  SEL_W  requester 0 opcode.
- rsp0_valid  out  1  one-cycle pulse, result for requester 0.
- req1_valid, req1_ready, req1_a, req1_b, req1_sel, rsp1_valid  same as requester 0, for requester 1.
- rsp_result  out  WIDTH  result, shared by both responses.
- rsp_carry  out  1  carry, shared by both responses.
- alu_a, alu_b  out  WIDTH  to ALU A/B.
- alu_sel  out  SEL_W  to ALU_Sel.
- alu_out  in  WIDTH  from ALU_Out.
- alu_carry  in  1  from CarryOut.

Behaviour:
- Reset (rst=1 at a clk edge):
  - State goes to IDLE; last_grant=1 (so req0 wins the first tie); counter=0.
  - All outputs are 0: ready, rsp_valid, rsp_result, rsp_carry, alu_a, alu_b, alu_sel.
  - Reset mid-operation abandons the op: no response is emitted, and the requester must re-issue.
- FSM states IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - If any req*_valid is high, pick the winner.
    - Both valid: grant the one not equal to last_grant.
    - One valid: grant that one.
  - Assert the winner's req*_ready combinationally in the same cycle (the handshake completes in IDLE).
  - Latch the winner's a/b/sel into alu_a/alu_b/alu_sel; update last_grant; go to ISSUE.
  - No valid: stay in IDLE; ready outputs stay 0.
- ISSUE: ALU inputs are stable; load counter=ALU_LAT-1; go to WAIT.
- WAIT: if counter==0, capture alu_out/alu_carry into rsp_result/rsp_carry and go to RESP; else decrement.
- RESP:
  - rsp<grant>_valid=1 for exactly one cycle; go to IDLE.
  - rsp_result/rsp_carry hold their value until the next capture.
- Ready is never asserted outside IDLE; at most one ready is high per cycle.
- Requesters need not hold valid after ready. Operands are sampled only in the IDLE handshake cycle.
- Latency: handshake cycle T, response pulse at T+ALU_LAT+2. Throughput: one op per ALU_LAT+3 cycles.
- alu_a/alu_b/alu_sel hold their last value outside ISSUE/WAIT; they are not cleared between ops.
- Starvation bound: a continuously valid requester is granted within 2 arbitration rounds.
- A requester that drops valid in the handshake cycle is still granted if valid was sampled high; the decision is combinational on the current cycle.

Decomposition:
- Shared package holds:
  - FSM state encoding (IDLE=2'd0, ISSUE=2'd1, WAIT=2'd2, RESP=2'd3).
  - WIDTH/SEL_W defaults, shared with the alu.
- One natural sub-module, rr_arb2:
  - Inputs: two request bits and last_grant.
  - Outputs: one-hot grant.
  - Purely combinational, reusable elsewhere.
- Counter and FSM stay in alu_arbiter.

Test Plan:
1. Reset: hold rst for 3 cycles with both valids high -> all outputs 0, no ready; the first release cycle grants req0.
2. Single op: req0 A=32'hAE21, B=32'h25F0, sel=4'h0 (add), ALU_LAT=1 -> req0_ready at T; rsp0_valid only at T+3; rsp_result=32'hD411, rsp_carry=0; rsp1_valid stays 0.
3. Carry: req1 A=32'hFFFFFFFF, B=32'h1, sel=4'h0 -> rsp1_valid pulse, rsp_result=0, rsp_carry=1.
4. Contention: both valid continuously for 6 ops -> grants alternate 0,1,0,1,0,1; responses spaced 4 cycles apart; each result matches the ALU reference model for that requester's operands.
5. Latency sweep: ALU_LAT=3 -> response at T+5; ready held 0 throughout ISSUE/WAIT/RESP even with valid high.
6. Mid-op reset: assert rst in WAIT -> no rsp pulse; state IDLE next cycle; the next op completes normally with correct result.
